srl_fifo_ctrl: RTL
==================

Name: srl_fifo_ctrl

Overview:
- Control and storage wrapper for a shift-register (SRL) FIFO used on start/data channels between dataflow PEs in the Linear_Layer pipeline.
- Tracks occupancy and drives the shift-enable and read address of an internal SRL array.
- Presents an HLS-style full_n/empty_n handshake to producer and consumer.
- Flags are registered; no combinational path from inputs to if_full_n or if_empty_n.

Parameters:
- DATA_WIDTH, 1, width of each stored word.
- ADDR_WIDTH, 1, read-address width; must satisfy 2**ADDR_WIDTH >= DEPTH.
- DEPTH, 2, number of entries, legal range 2..64.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- if_write_ce  in  1  write-side clock enable; when 0 the write is ignored.
- if_write  in  1  producer write request.
- if_din  in  DATA_WIDTH  write data.
- if_full_n  out  1  1 = space available (registered).
- if_read_ce  in  1  read-side clock enable; when 0 the read is ignored.
- if_read  in  1  consumer read request.
- if_dout  out  DATA_WIDTH  head-of-FIFO data, combinational from the SRL array at the current read address.
- if_empty_n  out  1  1 = data available (registered).
- if_num_data_valid  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - count=0, rd_addr=0, if_empty_n=0, if_full_n=1.
  - SRL array is not reset (preserves SRL inference); contents are don't-care.
- Accept rules, evaluated on registered flags:
  - push = if_write & if_write_ce & if_full_n
  - pop = if_read & if_read_ce & if_empty_n
- Storage shift: on push, SRL[0] <= if_din and SRL[i+1] <= SRL[i] for all i; no shift otherwise.
- Occupancy and read address per cycle:
  - push only: count+1; rd_addr+1, except when count was 0, in which case rd_addr stays 0.
  - pop only: count-1; rd_addr-1, except when count was 1, in which case rd_addr stays 0.
  - push and pop: count and rd_addr unchanged. The new word shifts in while the head is consumed.
  - neither: hold.
- Flags, registered from next-state count:
  - if_empty_n_next = (count_next != 0)
  - if_full_n_next = (count_next != DEPTH)
- Latency:
  - Write to if_empty_n rising: 1 cycle.
  - Read to if_full_n rising: 1 cycle.
  - Data written in cycle N is visible on if_dout from cycle N+1.
- Boundary conditions:
  - Full (count=DEPTH) with push and pop asserted: only the pop is accepted (if_full_n=0 blocks the push). Result: count=DEPTH-1, if_full_n=1 next cycle.
  - Empty with push and pop asserted: only the push is accepted, with no bypass. Result: count=1, if_empty_n=1 next cycle.
  - Write while full or read while empty: ignored; no state change; storage unchanged.
  - rd_addr never wraps; it stays in 0..DEPTH-1.
  - When empty, if_dout shows SRL[0] and is don't-care.
  - if_num_data_valid equals count, registered.
- Reset mid-operation: all pointer and flag state returns to reset values immediately (asynchronously). The next write after release lands at rd_addr 0.

Optional Feature:
- Macro: SRL_FIFO_CTRL_WATERMARK_EN.
- When defined, two extra outputs are added:
  - wm_peak [ADDR_WIDTH+1]: highest count reached since reset, updated the cycle after count rises.
  - ovf_sticky [1]: sets when if_write & if_write_ce is asserted while if_full_n=0; clears only on reset. Both reset to 0.
- When undefined, these ports and registers do not exist. Core behaviour is identical in both builds.

Test Plan:
- Reset with DEPTH=4: hold reset_n=0 for 3 cycles, release -> if_empty_n=0, if_full_n=1, if_num_data_valid=0.
- Fill then drain, DEPTH=4:
  - Write 0xA,0xB,0xC,0xD on consecutive cycles -> if_full_n=0 after the 4th edge, count=4.
  - Then read 4 times -> if_dout sequence A,B,C,D; if_empty_n=0 after the last read.
- Simultaneous push/pop at count=2 (holding 1,2): write 3 with a read -> if_dout goes 1 then 2; count stays 2; rd_addr unchanged.
- Full with write+read, DEPTH=4 holding 1..4, if_din=9 -> only the pop is accepted; count=3; word 9 is absent; if_full_n=1 next cycle.
- Empty with write+read, if_din=5 -> count=1, if_empty_n=1 next cycle, if_dout=5; if_read_ce=0 blocks a subsequent read.
- Watermark build: write 3 words, read 2, then write while full at DEPTH=4 -> wm_peak=3 after the first phase, ovf_sticky=1 after the blocked write. Asynchronous reset mid-stream clears all state.

Source files
------------

// File: rtl/srl_fifo_ctrl.sv
// Shift-register FIFO with registered full_n/empty_n handshake and occupancy count.
// Optional occupancy watermark and overflow flag: define SRL_FIFO_CTRL_WATERMARK_EN.
module srl_fifo_ctrl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
`ifdef SRL_FIFO_CTRL_WATERMARK_EN
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic [ADDR_WIDTH:0]   wm_peak,
  output logic                  ovf_sticky
`else
  output logic [ADDR_WIDTH:0]   if_num_data_valid
`endif
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C    = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO_C = {(ADDR_WIDTH + 1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE_C  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO_C = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE_C  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] srl_r [DEPTH];
  logic [ADDR_WIDTH:0]   count_r;
  logic [ADDR_WIDTH-1:0] rd_addr_r;
  logic                  empty_n_r;
  logic                  full_n_r;

  logic                  push_s;
  logic                  pop_s;
  logic [ADDR_WIDTH:0]   count_next_s;
  logic [ADDR_WIDTH-1:0] rd_addr_next_s;
  logic [DATA_WIDTH-1:0] dout_s;

  // Accept decisions use only the registered flags, never the live inputs' effect.
  always_comb begin
    push_s = if_write & if_write_ce & full_n_r;
    pop_s  = if_read  & if_read_ce  & empty_n_r;
  end

  // Next occupancy and read address; the newest word enters at index 0 so the head moves up.
  always_comb begin
    count_next_s   = count_r;
    rd_addr_next_s = rd_addr_r;
    case ({push_s, pop_s})
      2'b10: begin
        count_next_s = count_r + CNT_ONE_C;
        if (count_r == CNT_ZERO_C) begin
          rd_addr_next_s = ADDR_ZERO_C;
        end else begin
          rd_addr_next_s = rd_addr_r + ADDR_ONE_C;
        end
      end
      2'b01: begin
        count_next_s = count_r - CNT_ONE_C;
        if (count_r == CNT_ONE_C) begin
          rd_addr_next_s = ADDR_ZERO_C;
        end else begin
          rd_addr_next_s = rd_addr_r - ADDR_ONE_C;
        end
      end
      default: begin
        count_next_s   = count_r;
        rd_addr_next_s = rd_addr_r;
      end
    endcase
  end

  // Pointer, occupancy and handshake flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r   <= CNT_ZERO_C;
      rd_addr_r <= ADDR_ZERO_C;
      empty_n_r <= 1'b0;
      full_n_r  <= 1'b1;
    end else begin
      count_r   <= count_next_s;
      rd_addr_r <= rd_addr_next_s;
      empty_n_r <= (count_next_s != CNT_ZERO_C);
      full_n_r  <= (count_next_s != DEPTH_C);
    end
  end

  // Storage shift; deliberately unreset so it maps onto SRL primitives.
  always_ff @(posedge clk) begin
    if (push_s) begin
      srl_r[0] <= if_din;
      for (int i = 1; i < DEPTH; i++) begin
        srl_r[i] <= srl_r[i-1];
      end
    end
  end

  // Head-of-FIFO read mux; addresses beyond DEPTH-1 are unreachable and fall back to entry 0.
  always_comb begin
    dout_s = srl_r[0];
    for (int i = 1; i < DEPTH; i++) begin
      if (rd_addr_r == ADDR_WIDTH'(i)) begin
        dout_s = srl_r[i];
      end else begin
        dout_s = dout_s;
      end
    end
  end

  assign if_dout           = dout_s;
  assign if_full_n         = full_n_r;
  assign if_empty_n        = empty_n_r;
  assign if_num_data_valid = count_r;

`ifdef SRL_FIFO_CTRL_WATERMARK_EN
  logic [ADDR_WIDTH:0] wm_peak_r;
  logic                ovf_sticky_r;

  // Peak follows the registered count one cycle late; overflow latches until reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wm_peak_r    <= CNT_ZERO_C;
      ovf_sticky_r <= 1'b0;
    end else begin
      if (count_r > wm_peak_r) begin
        wm_peak_r <= count_r;
      end
      if (if_write & if_write_ce & ~full_n_r) begin
        ovf_sticky_r <= 1'b1;
      end
    end
  end

  assign wm_peak    = wm_peak_r;
  assign ovf_sticky = ovf_sticky_r;
`endif

endmodule
